// File: rtl/ual_pkg.sv
// ual_pkg: shared definitions for the bit-serial ALU sequencer.
//   - ALU op codes (3-bit), slice function selects (2-bit)
//   - FSM state encoding
//   - op_decode(): maps an ALU op to the slice control bits
// No ports (package).
package ual_pkg;

    localparam logic [2:0] UAL_AND = 3'd0;
    localparam logic [2:0] UAL_OR  = 3'd1;
    localparam logic [2:0] UAL_ADD = 3'd2;
    localparam logic [2:0] UAL_SUB = 3'd3;
    localparam logic [2:0] UAL_SLT = 3'd4;
    localparam logic [2:0] UAL_NOR = 3'd5;

    localparam logic [1:0] SEL_AND = 2'b00;
    localparam logic [1:0] SEL_OR  = 2'b01;
    localparam logic [1:0] SEL_ADD = 2'b10;
    localparam logic [1:0] SEL_SET = 2'b11;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

    typedef struct packed {
        logic       inva;
        logic       invb;
        logic       ci0;
        logic [1:0] sel;
    } slice_ctrl_t;

    function automatic slice_ctrl_t op_decode(input logic [2:0] op);
        slice_ctrl_t c;
        c = '{inva: 1'b0, invb: 1'b0, ci0: 1'b0, sel: SEL_SET};
        case (op)
            UAL_AND: c.sel = SEL_AND;
            UAL_OR:  c.sel = SEL_OR;
            UAL_ADD: c.sel = SEL_ADD;
            UAL_SUB, UAL_SLT: begin
                c.invb = 1'b1;
                c.ci0  = 1'b1;
                c.sel  = SEL_ADD;
            end
            // NOR via De Morgan: ~a & ~b
            UAL_NOR: begin
                c.inva = 1'b1;
                c.invb = 1'b1;
                c.sel  = SEL_AND;
            end
            default: c.sel = SEL_SET;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/ual_serial_seq_if.sv
// ual_serial_seq_if: request/result bundle of the bit-serial ALU sequencer.
//   start, op, a, b       : requester -> sequencer
//   busy, done, result,
//   zero, ovf             : sequencer -> requester (ovf only with UAL_SER_OVF_EN)
// Modports: master (requester), slave (sequencer).
interface ual_serial_seq_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             zero;
`ifdef UAL_SER_OVF_EN
    logic             ovf;
`endif

    modport master (
        output start, op, a, b,
        input  busy, done, result, zero
`ifdef UAL_SER_OVF_EN
        , input ovf
`endif
    );

    modport slave (
        input  start, op, a, b,
        output busy, done, result, zero
`ifdef UAL_SER_OVF_EN
        , output ovf
`endif
    );

endinterface

// File: rtl/ual_serial_seq_slice.sv
// ual1: one-bit ALU slice.
//   a_i, b_i        operand bits
//   inva_i, invb_i  operand inversion
//   ci_i            carry in
//   set_i           value passed through when sel_i == SEL_SET
//   sel_i           function select (AND / OR / ADD / SET)
//   f_o             selected function output
//   co_o            adder carry out
//   sgn_o           adder sum bit (used as sign at the MSB)
module ual1
    import ual_pkg::*;
(
    input  logic       a_i,
    input  logic       b_i,
    input  logic       inva_i,
    input  logic       invb_i,
    input  logic       ci_i,
    input  logic       set_i,
    input  logic [1:0] sel_i,
    output logic       f_o,
    output logic       co_o,
    output logic       sgn_o
);
    logic ai, bi, sum;

    assign ai    = a_i ^ inva_i;
    assign bi    = b_i ^ invb_i;
    assign sum   = ai ^ bi ^ ci_i;
    assign co_o  = (ai & bi) | (ai & ci_i) | (bi & ci_i);
    assign sgn_o = sum;

    always_comb begin
        f_o = 1'b0;
        unique case (sel_i)
            SEL_AND: f_o = ai & bi;
            SEL_OR:  f_o = ai | bi;
            SEL_ADD: f_o = sum;
            SEL_SET: f_o = set_i;
            default: f_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/ual_serial_seq.sv
// ual_serial_seq: bit-serial ALU sequencer. Runs one ual1 slice for WIDTH
// cycles, LSB first, and assembles a WIDTH-bit result plus flags.
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    ual_serial_seq_if.slave (start/op/a/b in; busy/done/result/zero/ovf out)
// Optional: define UAL_SER_OVF_EN to add the signed-overflow flag (bus.ovf).
module ual_serial_seq
    import ual_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    ual_serial_seq_if.slave       bus
);
    localparam int unsigned        CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0]   IDX_LAST = CNT_W'(WIDTH - 1);

    state_e           state_q;
    logic [WIDTH-1:0] a_sh_q, b_sh_q, res_sh_q, result_q;
    logic [WIDTH-1:0] result_d;
    logic [2:0]       op_q;
    logic [CNT_W-1:0] idx_q;
    logic             carry_q, cin_msb_q, cout_msb_q, sum_msb_q;
    logic             busy_q, done_q, zero_q;
    slice_ctrl_t      run_ctrl, start_ctrl;
    logic             f, co, sgn;
`ifdef UAL_SER_OVF_EN
    logic             ovf_q, ovf_d;
`endif

    assign run_ctrl   = op_decode(op_q);
    assign start_ctrl = op_decode(bus.op);

    ual1 u_slice (
        .a_i    (a_sh_q[0]),
        .b_i    (b_sh_q[0]),
        .inva_i (run_ctrl.inva),
        .invb_i (run_ctrl.invb),
        .ci_i   (carry_q),
        .set_i  (1'b0),
        .sel_i  (run_ctrl.sel),
        .f_o    (f),
        .co_o   (co),
        .sgn_o  (sgn)
    );

    // SLT: true sign of a-b is the MSB sum bit corrected by the overflow term.
    always_comb begin
        result_d = res_sh_q;
        if (op_q == UAL_SLT) begin
            result_d = {{(WIDTH-1){1'b0}}, sum_msb_q ^ (cin_msb_q ^ cout_msb_q)};
        end
    end

`ifdef UAL_SER_OVF_EN
    assign ovf_d = ((op_q == UAL_ADD) || (op_q == UAL_SUB)) & (cin_msb_q ^ cout_msb_q);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            a_sh_q     <= '0;
            b_sh_q     <= '0;
            res_sh_q   <= '0;
            result_q   <= '0;
            op_q       <= UAL_AND;
            idx_q      <= '0;
            carry_q    <= 1'b0;
            cin_msb_q  <= 1'b0;
            cout_msb_q <= 1'b0;
            sum_msb_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            zero_q     <= 1'b1;
`ifdef UAL_SER_OVF_EN
            ovf_q      <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (bus.start) begin
                        a_sh_q  <= bus.a;
                        b_sh_q  <= bus.b;
                        op_q    <= bus.op;
                        idx_q   <= '0;
                        carry_q <= start_ctrl.ci0;
                        busy_q  <= 1'b1;
                        state_q <= StRun;
                    end
                end
                StRun: begin
                    res_sh_q <= {f, res_sh_q[WIDTH-1:1]};
                    carry_q  <= co;
                    a_sh_q   <= a_sh_q >> 1;
                    b_sh_q   <= b_sh_q >> 1;
                    if (idx_q == IDX_LAST) begin
                        cin_msb_q  <= carry_q;
                        cout_msb_q <= co;
                        sum_msb_q  <= sgn;
                        state_q    <= StDone;
                    end else begin
                        idx_q <= idx_q + CNT_W'(1);
                    end
                end
                StDone: begin
                    result_q <= result_d;
                    zero_q   <= (result_d == '0);
`ifdef UAL_SER_OVF_EN
                    ovf_q    <= ovf_d;
`endif
                    done_q   <= 1'b1;
                    busy_q   <= 1'b0;
                    state_q  <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.result = result_q;
    assign bus.zero   = zero_q;
`ifdef UAL_SER_OVF_EN
    assign bus.ovf    = ovf_q;
`endif

endmodule

// File: tb/tb_ual_serial_seq.sv
// tb_ual_serial_seq: self-checking bench for ual_serial_seq at WIDTH=8 with a
// WIDTH=32 smoke instance. Expected values come from an arithmetic model of
// the ALU ops (signed compare/overflow via plain integer ranges).
module tb_ual_serial_seq;
    import ual_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ual_serial_seq_if #(.WIDTH(8))  bus8 ();
    ual_serial_seq_if #(.WIDTH(32)) bus32 ();

    ual_serial_seq #(.WIDTH(8))  dut   (.clk(clk), .rst_n(rst_n), .bus(bus8));
    ual_serial_seq #(.WIDTH(32)) dut32 (.clk(clk), .rst_n(rst_n), .bus(bus32));

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Returns {ovf, zero, result[31:0]} for a w-bit operation.
    function automatic logic [33:0] model(input int w, input logic [2:0] op,
                                          input logic [31:0] a, input logic [31:0] b);
        longint           mask, sa, sb, s, lo, hi;
        logic [31:0]      r;
        logic             ov;
        mask = (longint'(1) << w) - 1;
        lo   = -(longint'(1) << (w - 1));
        hi   = (longint'(1) << (w - 1)) - 1;
        sa   = longint'(a) - (a[w-1] ? (longint'(1) << w) : longint'(0));
        sb   = longint'(b) - (b[w-1] ? (longint'(1) << w) : longint'(0));
        ov   = 1'b0;
        r    = '0;
        case (op)
            3'd0: r = a & b;
            3'd1: r = a | b;
            3'd2: begin s = sa + sb; r = 32'(s & mask); ov = (s < lo) || (s > hi); end
            3'd3: begin s = sa - sb; r = 32'(s & mask); ov = (s < lo) || (s > hi); end
            3'd4: r = (sa < sb) ? 32'd1 : 32'd0;
            3'd5: r = 32'(~(longint'(a) | longint'(b)) & mask);
            default: r = '0;
        endcase
        return {ov, (r == 32'd0), r};
    endfunction

    task automatic drive(input int w, input logic s, input logic [2:0] op,
                         input logic [31:0] a, input logic [31:0] b);
        if (w == 32) begin
            bus32.start = s; bus32.op = op; bus32.a = a; bus32.b = b;
        end else begin
            bus8.start = s; bus8.op = op; bus8.a = a[7:0]; bus8.b = b[7:0];
        end
    endtask

    task automatic sample(input int w, output logic busy, output logic done,
                          output logic zero, output logic ovf, output logic [31:0] res);
        ovf = 1'b0;
        if (w == 32) begin
            busy = bus32.busy; done = bus32.done; zero = bus32.zero; res = bus32.result;
`ifdef UAL_SER_OVF_EN
            ovf = bus32.ovf;
`endif
        end else begin
            busy = bus8.busy; done = bus8.done; zero = bus8.zero; res = {24'b0, bus8.result};
`ifdef UAL_SER_OVF_EN
            ovf = bus8.ovf;
`endif
        end
    endtask

    // One operation: start, scramble inputs during RUN, wait for done (bounded),
    // check latency/result/flags and the single-cycle done pulse.
    // restart_at > 0 re-pulses start at that cycle and checks it is ignored.
    task automatic run_op(input int w, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int restart_at);
        logic        busy, done, zero, ovf;
        logic [31:0] res;
        logic [33:0] exp;
        int          cyc, extra_done;
        exp = model(w, op, a, b);
        @(negedge clk);
        drive(w, 1'b1, op, a, b);
        @(posedge clk);
        #1;
        drive(w, 1'b0, 3'($urandom_range(0, 7)), $urandom, $urandom);
        cyc  = 0;
        done = 1'b0;
        while (!done && cyc < 4 * w) begin
            @(posedge clk);
            #1;
            cyc++;
            sample(w, busy, done, zero, ovf, res);
            if (cyc == 1) check("busy_in_run", 64'(busy), 64'd1);
            if (restart_at > 0 && cyc == restart_at)
                drive(w, 1'b1, 3'($urandom_range(0, 7)), $urandom, $urandom);
            if (restart_at > 0 && cyc == restart_at + 1)
                drive(w, 1'b0, 3'($urandom_range(0, 7)), $urandom, $urandom);
        end
        check("done_latency", 64'(cyc), 64'(w + 1));
        check("result", 64'(res), 64'(exp[31:0]));
        check("zero", 64'(zero), 64'(exp[32]));
        check("busy_at_done", 64'(busy), 64'd0);
`ifdef UAL_SER_OVF_EN
        check("ovf", 64'(ovf), 64'(exp[33]));
`endif
        @(posedge clk);
        #1;
        sample(w, busy, done, zero, ovf, res);
        check("done_one_cycle", 64'(done), 64'd0);
        check("result_held", 64'(res), 64'(exp[31:0]));
        if (restart_at > 0) begin
            extra_done = 0;
            for (int i = 0; i < w + 4; i++) begin
                @(posedge clk);
                #1;
                sample(w, busy, done, zero, ovf, res);
                if (done || busy) extra_done++;
            end
            check("restart_ignored", 64'(extra_done), 64'd0);
            check("result_after_restart", 64'(res), 64'(exp[31:0]));
        end
    endtask

    initial begin : stim
        logic        busy, done, zero, ovf;
        logic [31:0] res;

        drive(8, 1'b0, 3'd0, 32'd0, 32'd0);
        drive(32, 1'b0, 3'd0, 32'd0, 32'd0);
        #12;
        sample(8, busy, done, zero, ovf, res);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_result", 64'(res), 64'd0);
        check("rst_zero", 64'(zero), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed cases
        run_op(8, UAL_ADD, 32'h7F, 32'h01, 0);
        run_op(8, UAL_SUB, 32'h05, 32'h05, 0);
        run_op(8, UAL_SLT, 32'h80, 32'h7F, 0);
        run_op(8, UAL_SLT, 32'h7F, 32'h80, 0);
        run_op(8, UAL_NOR, 32'hF0, 32'h0C, 0);
        run_op(8, UAL_OR,  32'hF0, 32'h0C, 0);
        run_op(8, 3'd7,    32'hFF, 32'hFF, 0);
        run_op(8, UAL_AND, 32'hF0, 32'h3C, 0);

        // Start pulsed during RUN is dropped
        run_op(8, UAL_ADD, 32'h12, 32'h34, 3);

        // Randomized ops at WIDTH=8
        for (int i = 0; i < 30; i++)
            run_op(8, 3'($urandom_range(0, 7)), 32'($urandom_range(0, 255)),
                   32'($urandom_range(0, 255)), 0);

        // Reset mid-RUN
        run_op(8, UAL_ADD, 32'h10, 32'h20, 0);
        @(negedge clk);
        drive(8, 1'b1, UAL_ADD, 32'h33, 32'h11);
        @(posedge clk);
        #1;
        drive(8, 1'b0, UAL_ADD, 32'h33, 32'h11);
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        sample(8, busy, done, zero, ovf, res);
        check("midrun_rst_busy", 64'(busy), 64'd0);
        check("midrun_rst_done", 64'(done), 64'd0);
        check("midrun_rst_result", 64'(res), 64'd0);
        check("midrun_rst_zero", 64'(zero), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(8, UAL_ADD, 32'h01, 32'h01, 0);

        // WIDTH=32 smoke
        run_op(32, UAL_ADD, 32'h7FFF_FFFF, 32'h0000_0001, 0);
        run_op(32, UAL_SLT, 32'h8000_0000, 32'h0000_0001, 0);
        for (int i = 0; i < 6; i++)
            run_op(32, 3'($urandom_range(0, 7)), $urandom, $urandom, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
